// File: rtl/key_sw_pkg.sv
// Shared types and default timing constants for the key/switch input block.
package key_sw_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;

    localparam int unsigned DEB_CNT_W   = 24;
    localparam int unsigned HOLD_CNT_W  = 28;
    localparam int unsigned START_CNT_W = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, restartable debounce counter, level and edge pulses.
module debounce_bit
    import key_sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic arm,
    output logic level,
    output logic rise,
    output logic fall,
    output logic change_c
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic [DEB_CNT_W-1:0] cnt;

    // Level flips once the difference has persisted for the full window.
    assign change_c = (sync2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= change_c & arm & sync2;
            fall  <= change_c & arm & ~sync2;
            if (change_c) begin
                level <= sync2;
            end
            if (change_c || (sync2 == level)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DEB_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_sw_input.sv
// Debounced push-buttons with press/release/long-press pulses, debounced switches, sticky event flag.
module key_sw_input
    import key_sw_pkg::*;
#(
    parameter int unsigned N_KEY           = 2,
    parameter int unsigned N_SW            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_KEY-1:0] key_n,
    input  logic [N_SW-1:0]  sw,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_KEY-1:0] key_long,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_change,
    output logic             evt_pending,
    input  logic             evt_clr
);

    localparam logic [HOLD_CNT_W-1:0]  HOLD_LAST  = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [START_CNT_W-1:0] START_LAST = START_CNT_W'(DEBOUNCE_CYCLES + 1);

    logic [N_KEY-1:0]       key_change_c;
    logic [N_SW-1:0]        sw_change_c;
    logic [N_SW-1:0]        sw_rise;
    logic [N_SW-1:0]        sw_fall;
    logic [N_SW-1:0]        primed;
    logic [START_CNT_W-1:0] start_cnt;
    logic                   start_done;

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        key_state_t            state;
        key_state_t            state_nxt;
        logic [HOLD_CNT_W-1:0] hold;
        logic [HOLD_CNT_W-1:0] hold_nxt;
        logic                  long_q;
        logic                  long_nxt;
        logic                  press_c;
        logic                  release_c;

        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw      (~key_n[k]),
            .arm      (1'b1),
            .level    (key_level[k]),
            .rise     (key_press[k]),
            .fall     (key_release[k]),
            .change_c (key_change_c[k])
        );

        assign press_c   = key_change_c[k] & ~key_level[k];
        assign release_c = key_change_c[k] &  key_level[k];
        assign key_long[k] = long_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                hold   <= hold_nxt;
                long_q <= long_nxt;
            end
        end

        // Release wins over reaching the hold threshold in the same cycle.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold;
            long_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    if (press_c) begin
                        state_nxt = PRESSED;
                        hold_nxt  = '0;
                    end
                end
                PRESSED: begin
                    if (release_c) begin
                        state_nxt = IDLE;
                    end else if (hold == HOLD_LAST) begin
                        state_nxt = HELD;
                        long_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold + HOLD_CNT_W'(1);
                    end
                end
                HELD: begin
                    if (release_c) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    for (genvar s = 0; s < N_SW; s++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw      (sw[s]),
            .arm      (primed[s]),
            .level    (sw_level[s]),
            .rise     (sw_rise[s]),
            .fall     (sw_fall[s]),
            .change_c (sw_change_c[s])
        );
    end

    assign sw_change = sw_rise | sw_fall;

    // A switch bit is primed after its first settle or once the startup window has elapsed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_cnt  <= '0;
            start_done <= 1'b0;
            primed     <= '0;
        end else begin
            if (!start_done) begin
                if (start_cnt == START_LAST) begin
                    start_done <= 1'b1;
                end else begin
                    start_cnt <= start_cnt + START_CNT_W'(1);
                end
            end
            primed <= primed | sw_change_c | {N_SW{start_done}};
        end
    end

    // Setting has priority over clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_pending <= 1'b0;
        end else begin
            evt_pending <= (|key_press) | (|key_long) | (|sw_change) | (evt_pending & ~evt_clr);
        end
    end

endmodule

// File: tb/tb_key_sw_input.sv
// Directed and random stimulus for key_sw_input against a sliding-window reference model.
module tb_key_sw_input;

    localparam int unsigned NK = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned NB = NK + NS;
    localparam int unsigned D  = 8;
    localparam int unsigned H  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NS-1:0] sw = 4'b1010;
    logic          evt_clr = 1'b0;
    logic [NK-1:0] key_level, key_press, key_release, key_long;
    logic [NS-1:0] sw_level, sw_change;
    logic          evt_pending;

    always #5 clk = ~clk;

    key_sw_input #(.N_KEY(NK), .N_SW(NS), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .sw          (sw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .sw_level    (sw_level),
        .sw_change   (sw_change),
        .evt_pending (evt_pending),
        .evt_clr     (evt_clr)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: bit b < NK is a key (1 = pressed), the rest are switches.
    bit [D+1:0]    hist [NB];
    bit [NB-1:0]   m_lvl, m_rise, m_fall, m_seen;
    bit [NK-1:0]   m_long, m_held, m_long_done;
    bit [NS-1:0]   m_swchg;
    int            m_age [NK];
    bit            m_evt, m_prev_any;
    int            m_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < int'(NB); b++) hist[b] = '0;
        m_lvl = '0; m_rise = '0; m_fall = '0; m_seen = '0;
        m_long = '0; m_held = '0; m_long_done = '0; m_swchg = '0;
        for (int k = 0; k < int'(NK); k++) m_age[k] = 0;
        m_evt = 1'b0; m_prev_any = 1'b0; m_t = 0;
    endtask

    // A bit settles when its last D synchronized samples all disagree with the current level.
    task automatic model_edge(input bit [NB-1:0] raw, input bit clr);
        bit          flip;
        bit [NK-1:0] lg;
        bit [NS-1:0] sc;
        m_t++;
        m_evt = m_prev_any | (m_evt & ~clr);
        m_rise = '0; m_fall = '0; lg = '0; sc = '0;
        for (int b = 0; b < int'(NB); b++) begin
            hist[b] = {hist[b][D:0], raw[b]};
            flip = (hist[b][D+1:2] == {D{~m_lvl[b]}});
            if (flip) begin
                if (m_lvl[b]) m_fall[b] = 1'b1;
                else          m_rise[b] = 1'b1;
                m_lvl[b] = ~m_lvl[b];
                if (b >= int'(NK)) begin
                    if (m_seen[b] || m_t > int'(D) + 3) sc[b-int'(NK)] = 1'b1;
                    m_seen[b] = 1'b1;
                end
            end
        end
        for (int k = 0; k < int'(NK); k++) begin
            if (m_rise[k]) begin
                m_held[k] = 1'b1; m_age[k] = 0; m_long_done[k] = 1'b0;
            end else if (m_fall[k]) begin
                m_held[k] = 1'b0;
            end else if (m_held[k]) begin
                m_age[k]++;
                if (m_age[k] == int'(H) && !m_long_done[k]) begin
                    lg[k] = 1'b1;
                    m_long_done[k] = 1'b1;
                end
            end
        end
        m_long = lg;
        m_swchg = sc;
        m_prev_any = (|m_rise[NK-1:0]) | (|lg) | (|sc);
    endtask

    task automatic check_all();
        check("key_level",   32'(key_level),   32'(m_lvl[NK-1:0]));
        check("key_press",   32'(key_press),   32'(m_rise[NK-1:0]));
        check("key_release", 32'(key_release), 32'(m_fall[NK-1:0]));
        check("key_long",    32'(key_long),    32'(m_long));
        check("sw_level",    32'(sw_level),    32'(m_lvl[NB-1:NK]));
        check("sw_change",   32'(sw_change),   32'(m_swchg));
        check("evt_pending", 32'(evt_pending), 32'(m_evt));
    endtask

    task automatic step(input logic [NK-1:0] kn, input logic [NS-1:0] s, input logic clr);
        key_n = kn; sw = s; evt_clr = clr;
        @(posedge clk);
        model_edge({s, ~kn}, clr);
        #1;
        check_all();
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int            press_at, long_at, n_long, n_rel, n_cnt;
        logic [NK-1:0] kn;
        logic [NS-1:0] sv;

        #2;
        apply_reset(3);

        // Switches present through reset load silently.
        for (int i = 1; i <= 10; i++) begin
            step(2'b11, 4'b1010, 1'b0);
            if (i == 9)  check("sw_prime_before", 32'(sw_level), 32'h0);
            if (i == 10) check("sw_prime_at10", 32'(sw_level), 32'ha);
        end
        for (int i = 11; i <= 20; i++) step(2'b11, 4'b1010, 1'b0);
        n_cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            step(2'b11, 4'b1110, 1'b0);
            if (sw_change[2]) n_cnt++;
        end
        check("sw2_pulses", 32'(n_cnt), 32'd1);
        step(2'b11, 4'b1110, 1'b1);

        // Clean press held 60 cycles; evt_clr coincides with key_press, then alone.
        press_at = -1; long_at = -1; n_long = 0;
        for (int i = 1; i <= 60; i++) begin
            step(2'b10, 4'b1110, (press_at > 0) && (i == press_at + 1 || i == press_at + 2));
            if (key_press[0] && press_at < 0) press_at = i;
            if (key_long[0]) begin n_long++; long_at = i; end
            if (press_at > 0 && i == press_at + 1) check("evt_set_wins", 32'(evt_pending), 32'd1);
            if (press_at > 0 && i == press_at + 2) check("evt_clr_alone", 32'(evt_pending), 32'd0);
        end
        check("press_latency", 32'(press_at), 32'd10);
        check("long_count", 32'(n_long), 32'd1);
        check("long_distance", 32'(long_at - press_at), 32'(H));
        n_rel = 0; n_long = 0;
        for (int i = 1; i <= 20; i++) begin
            step(2'b11, 4'b1110, 1'b0);
            if (key_release[0]) n_rel++;
            if (key_long[0]) n_long++;
        end
        check("release_count", 32'(n_rel), 32'd1);
        check("no_second_long", 32'(n_long), 32'd0);
        step(2'b11, 4'b1110, 1'b1);
        step(2'b11, 4'b1110, 1'b1);

        // Glitches on key 1 shorter than the debounce window are ignored.
        n_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) begin step(2'b01, 4'b1110, 1'b0); if (key_press[1]) n_cnt++; end
            for (int i = 0; i < 5; i++) begin step(2'b11, 4'b1110, 1'b0); if (key_press[1]) n_cnt++; end
        end
        check("glitch_press", 32'(n_cnt), 32'd0);
        check("glitch_level", 32'(key_level[1]), 32'd0);
        check("glitch_evt", 32'(evt_pending), 32'd0);

        // Reset in the middle of a debounce, key still held afterwards.
        for (int i = 0; i < 5; i++) step(2'b10, 4'b1110, 1'b0);
        apply_reset(2);
        check("rst_outputs", 32'({key_level, key_press, key_release, key_long, sw_level, sw_change, evt_pending}), 32'd0);
        press_at = -1;
        for (int i = 1; i <= 15; i++) begin
            step(2'b10, 4'b1110, 1'b0);
            if (key_press[0] && press_at < 0) press_at = i;
        end
        check("press_after_reset", 32'(press_at), 32'(D + 2));
        for (int i = 0; i < 20; i++) step(2'b11, 4'b1110, 1'b0);

        // Random activity with one reset in the middle.
        kn = 2'b11; sv = 4'b1110;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < int'(NK); k++) if ($urandom_range(0, 29) == 0) kn[k] = ~kn[k];
            for (int b = 0; b < int'(NS); b++) if ($urandom_range(0, 59) == 0) sv[b] = ~sv[b];
            if (c == 400) apply_reset(3);
            step(kn, sv, $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_sw_input.md
KEY_SW_INPUT -- requirements
Module: key_sw_input

Interface
REQ-001 SHALL have parameter N_KEY, default 2, number of active-low push-buttons.
REQ-002 SHALL have parameter N_SW, default 4, number of slide switches.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, which is 20 ms at 50 MHz; legal range 2..2^24-1.
REQ-004 SHALL have parameter HOLD_CYCLES, default 50_000_000, which is 1 s at 50 MHz; long-press threshold; legal range DEBOUNCE_CYCLES+1..2^28-1.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port key_n, input, N_KEY, raw asynchronous buttons, 0 = pressed.
REQ-008 SHALL have port sw, input, N_SW, raw asynchronous switches.
REQ-009 SHALL have port key_level, output, N_KEY, debounced level, 1 = pressed.
REQ-010 SHALL have port key_press, output, N_KEY, one-cycle pulse on debounced press.
REQ-011 SHALL have port key_release, output, N_KEY, one-cycle pulse on debounced release.
REQ-012 SHALL have port key_long, output, N_KEY, one-cycle pulse when a press has been held HOLD_CYCLES.
REQ-013 SHALL have port sw_level, output, N_SW, debounced switch levels.
REQ-014 SHALL have port sw_change, output, N_SW, one-cycle pulse on a debounced switch change.
REQ-015 SHALL have port evt_pending, output, 1, sticky flag set by any press, long or sw_change pulse.
REQ-016 SHALL have port evt_clr, input, 1, single-cycle clear of evt_pending.

Function
REQ-017 SHALL pass every raw input through a 2-flop synchronizer before any use.
REQ-018 SHALL debounce each bit independently: a counter restarts whenever the synchronized value differs from the current debounced value; the debounced value updates when the counter reaches DEBOUNCE_CYCLES-1 with the difference persisting.
REQ-019 SHALL give a raw-edge-to-level-change latency of exactly DEBOUNCE_CYCLES+2 cycles for a clean edge.
REQ-020 SHALL hold the debounced value and restart the count on any glitch shorter than DEBOUNCE_CYCLES cycles.
REQ-021 SHALL assert key_press, key_release and sw_change in the same cycle that the corresponding level output changes.
REQ-022 SHALL run a per-key FSM with states IDLE (released), PRESSED and HELD.
REQ-023 SHALL move IDLE->PRESSED on a debounced press and clear the hold counter.
REQ-024 SHALL move PRESSED->HELD when the hold counter reaches HOLD_CYCLES-1, emitting key_long once.
REQ-025 SHALL move PRESSED->IDLE or HELD->IDLE on a debounced release; a release in HELD still emits key_release.
REQ-026 SHALL saturate the hold counter in HELD, with no further key_long pulses until the next press.
REQ-027 SHALL treat switches as level sources: the first debounced value after reset loads silently into sw_level without a sw_change pulse (per-bit primed flag).
REQ-028 SHALL give a set priority over evt_clr when both coincide on evt_pending, leaving it 1.
REQ-029 SHALL keep all outputs registered with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, while rst is high, asynchronously force synchronizers, counters, key_level, all pulse outputs, sw_level, primed flags and evt_pending to 0, and every key FSM to IDLE.
REQ-031 SHALL, on release of rst, start debounce from zero; a key held through reset produces key_press DEBOUNCE_CYCLES+2 cycles after reset release.
REQ-032 SHALL discard, with no pulse, any event in progress when rst is asserted mid-debounce or mid-hold.

Structure
REQ-033 SHALL place the key FSM state enum (IDLE, PRESSED, HELD) and the default-cycle constants in shared package key_sw_pkg.
REQ-034 SHALL contain one sub-module, debounce_bit (synchronizer, counter, level, rise/fall pulses), instantiated N_KEY+N_SW times.

Verification (DEBOUNCE_CYCLES=8, HOLD_CYCLES=32)
REQ-035 SHALL cover: key_n[0] 1->0 clean at cycle 100 -> key_level[0]=1 and key_press[0] pulse at cycle 110, no other pulses.
REQ-036 SHALL cover: key_n[1] low for 5 cycles then high, repeated 4 times -> no key_press, key_level stays 0, evt_pending stays 0.
REQ-037 SHALL cover: key_n[0] held low 60 cycles -> exactly one key_long 32 cycles after key_press; on release, key_release with no second key_long.
REQ-038 SHALL cover: sw=4'b1010 during and after reset -> sw_level=4'b1010 at cycle 10 post-release with no sw_change; then sw[2] 0->1 -> single sw_change[2] pulse.
REQ-039 SHALL cover: evt_clr asserted in the same cycle as a key_press -> evt_pending stays 1; evt_clr alone the next cycle -> 0.
REQ-040 SHALL cover: rst asserted at cycle 5 of a debounce -> all outputs 0 immediately; after release with the key still held, key_press at DEBOUNCE_CYCLES+2.
